// File: rtl/uart_rx_frontend_if.sv
// Bus-side bundle of the UART receiver: serial line in, byte buffer and status out.
`timescale 1ns/1ps
interface uart_rx_frontend_if;
    logic       UART_RX;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    modport slave (
        input  UART_RX, rx_ack,
        output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
    );

    modport master (
        output UART_RX, rx_ack,
        input  rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, checks the stop bit and
// holds one byte until the CPU acknowledges it, flagging framing and overrun errors.
`timescale 1ns/1ps
module uart_rx_frontend #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic              sysclk,
    input  logic              reset,
    uart_rx_frontend_if.slave bus
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic             r_sync_p0;
    logic             r_sync_p1;
    logic             r_rx_prev;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_rx_s;
    logic             w_fall;
    logic             w_cnt_last;
    logic             w_cnt_mid;

    assign w_rx_s     = r_sync_p1;
    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_cnt_mid  = (r_cnt == CNT_MID);

    // Stage p0/p1: two-flop synchroniser; r_rx_prev gives the edge detector its history.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync_p0 <= 1'b1;
            r_sync_p1 <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync_p0 <= bus.UART_RX;
            r_sync_p1 <= r_sync_p0;
            r_rx_prev <= r_sync_p1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Ack first; a deliver or error later in this block takes precedence.
            if (bus.rx_ack) begin
                r_valid     <= 1'b0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_cnt_mid) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_cnt_last) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Decision at mid stop bit leaves half a bit of margin for the next start edge.
                S_STOP: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (!r_valid || bus.rx_ack) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // A held-low line (break) must go high before another start edge can count.
                S_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data      = r_data;
    assign bus.rx_valid     = r_valid;
    assign bus.rx_busy      = r_busy;
    assign bus.rx_frame_err = r_frame_err;
    assign bus.rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: directed frames, expected bytes queued at send time.
`timescale 1ns/1ps
module tb_uart_rx_frontend;

    localparam int BITC = 16;

    logic sysclk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_q[$];

    uart_rx_frontend_if bus();

    uart_rx_frontend #(
        .CLK_FREQ    (100_000_000),
        .BAUD        (6_250_000),
        .CLKS_PER_BIT(BITC)
    ) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: a new byte is presented when rx_valid rises or the held byte changes.
    logic       mon_prev_valid = 1'b0;
    logic [7:0] mon_prev_data  = 8'h00;
    always @(negedge sysclk) begin
        if (reset === 1'b1 && bus.rx_valid === 1'b1 &&
            (mon_prev_valid !== 1'b1 || bus.rx_data !== mon_prev_data)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_byte", {24'h0, bus.rx_data}, 32'hFFFF_FFFF);
            end else begin
                check("sb_byte", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
        mon_prev_valid = bus.rx_valid;
        mon_prev_data  = bus.rx_data;
    end

    // Caller is just after a negedge; every line change lands mid-cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_bits);
        bus.UART_RX = 1'b0;
        repeat (BITC) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            bus.UART_RX = d[i];
            repeat (BITC) @(negedge sysclk);
        end
        bus.UART_RX = stop_v;
        repeat (BITC * stop_bits) @(negedge sysclk);
        bus.UART_RX = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge sysclk);
        bus.rx_ack = 1'b1;
        @(negedge sysclk);
        bus.rx_ack = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (bus.rx_valid !== 1'b1 && k < 200) begin
            @(negedge sysclk);
            k++;
        end
        check(name, {31'h0, bus.rx_valid}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        bus.UART_RX = 1'b1;
        bus.rx_ack  = 1'b0;
        #100;
        @(negedge sysclk);
        reset = 1'b1;
        repeat (5) @(negedge sysclk);

        // Reset state with an idle line
        check("rst_data",  {24'h0, bus.rx_data},       32'h0);
        check("rst_valid", {31'h0, bus.rx_valid},      32'h0);
        check("rst_busy",  {31'h0, bus.rx_busy},       32'h0);
        check("rst_ferr",  {31'h0, bus.rx_frame_err},  32'h0);
        check("rst_ovr",   {31'h0, bus.rx_overrun},    32'h0);

        // Reset mid-frame abandons it; the all-ones tail cannot retrigger
        fork
            send_frame(8'hFF, 1'b1, 1);
            begin
                repeat (3 * BITC) @(negedge sysclk);
                check("midrst_busy_before", {31'h0, bus.rx_busy}, 32'h1);
                #2 reset = 1'b0;
                #1;
                check("midrst_busy_async", {31'h0, bus.rx_busy},  32'h0);
                check("midrst_valid",      {31'h0, bus.rx_valid}, 32'h0);
                @(negedge sysclk);
                reset = 1'b1;
            end
        join
        repeat (5) @(negedge sysclk);
        check("midrst_valid_after", {31'h0, bus.rx_valid}, 32'h0);
        check("midrst_busy_after",  {31'h0, bus.rx_busy},  32'h0);

        // Single good frame 0x03
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1);
        wait_valid("t2_valid");
        check("t2_ferr", {31'h0, bus.rx_frame_err}, 32'h0);
        check("t2_ovr",  {31'h0, bus.rx_overrun},   32'h0);
        ack_pulse();
        check("t2_valid_after_ack", {31'h0, bus.rx_valid}, 32'h0);

        // Overrun: second byte dropped, first kept
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1);
        send_frame(8'h06, 1'b1, 1);
        repeat (4) @(negedge sysclk);
        check("t3_data",  {24'h0, bus.rx_data},     32'h03);
        check("t3_valid", {31'h0, bus.rx_valid},    32'h1);
        check("t3_ovr",   {31'h0, bus.rx_overrun},  32'h1);
        ack_pulse();
        check("t3_ovr_clr",   {31'h0, bus.rx_overrun}, 32'h0);
        check("t3_valid_clr", {31'h0, bus.rx_valid},   32'h0);

        // Framing error with the line held low for three bit times
        fork
            send_frame(8'h00, 1'b0, 3);
            begin
                repeat (10 * BITC) @(negedge sysclk);
                check("t4_ferr",       {31'h0, bus.rx_frame_err}, 32'h1);
                check("t4_valid",      {31'h0, bus.rx_valid},     32'h0);
                check("t4_busy_break", {31'h0, bus.rx_busy},      32'h1);
                repeat (BITC) @(negedge sysclk);
                check("t4_busy_still", {31'h0, bus.rx_busy},      32'h1);
            end
        join
        repeat (5) @(negedge sysclk);
        check("t4_busy_released", {31'h0, bus.rx_busy},      32'h0);
        check("t4_ferr_sticky",   {31'h0, bus.rx_frame_err}, 32'h1);
        check("t4_valid_after",   {31'h0, bus.rx_valid},     32'h0);
        ack_pulse();
        check("t4_ferr_clr", {31'h0, bus.rx_frame_err}, 32'h0);

        // Glitch shorter than half a bit
        bus.UART_RX = 1'b0;
        repeat (5) @(negedge sysclk);
        bus.UART_RX = 1'b1;
        check("t5_busy_glitch", {31'h0, bus.rx_busy}, 32'h1);
        repeat (11) @(negedge sysclk);
        check("t5_busy_idle", {31'h0, bus.rx_busy},      32'h0);
        check("t5_ferr",      {31'h0, bus.rx_frame_err}, 32'h0);
        check("t5_ovr",       {31'h0, bus.rx_overrun},   32'h0);
        check("t5_valid",     {31'h0, bus.rx_valid},     32'h0);

        // Back-to-back 0x06, 0x74 with ack landing on the second deliver edge (155 cycles in)
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h74);
        send_frame(8'h06, 1'b1, 1);
        fork
            send_frame(8'h74, 1'b1, 1);
            begin
                repeat (154) @(posedge sysclk);
                @(negedge sysclk);
                bus.rx_ack = 1'b1;
                @(negedge sysclk);
                bus.rx_ack = 1'b0;
            end
        join
        repeat (4) @(negedge sysclk);
        check("t6_data",  {24'h0, bus.rx_data},      32'h74);
        check("t6_valid", {31'h0, bus.rx_valid},     32'h1);
        check("t6_ovr",   {31'h0, bus.rx_overrun},   32'h0);
        check("t6_ferr",  {31'h0, bus.rx_frame_err}, 32'h0);
        ack_pulse();
        check("t6_valid_clr", {31'h0, bus.rx_valid}, 32'h0);

        repeat (5) @(negedge sysclk);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
